// File: rtl/bpm_pkg.sv
// Shared types and default parameter values for the windowed heart-rate monitor.
package bpm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_COUNT_W       = 8;
    localparam int DEF_BPM_W         = 12;
    localparam int DEF_BPM_MULT      = 6;
    localparam int DEF_WINDOW_CYCLES = 100;
    localparam int DEF_ALARM_N       = 3;

endpackage

// File: rtl/bpm_window_monitor_if.sv
// Control inputs and per-window results of the heart-rate monitor.
interface bpm_window_monitor_if
    import bpm_pkg::*;
#(
    parameter int BPM_W = DEF_BPM_W
);
    logic             en;
    logic             pulse_in;
    logic [BPM_W-1:0] low_thresh;
    logic [BPM_W-1:0] high_thresh;
    logic [BPM_W-1:0] bpm;
    logic             bpm_valid;
    logic             bpm_state;
    logic             count_sat;
    logic             alarm;

    modport master (
        output en, pulse_in, low_thresh, high_thresh,
        input  bpm, bpm_valid, bpm_state, count_sat, alarm
    );

    modport slave (
        input  en, pulse_in, low_thresh, high_thresh,
        output bpm, bpm_valid, bpm_state, count_sat, alarm
    );

endinterface

// File: rtl/bpm_edge_counter.sv
// Rising-edge detector on the raw pulse line feeding a saturating edge counter.
module bpm_edge_counter
    import bpm_pkg::*;
#(
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pulse_in,
    input  logic               run,
    input  logic               close,
    output logic               pulse_edge,
    output logic [COUNT_W-1:0] pulse_cnt,
    output logic               cnt_sat
);

    logic pulse_q;

    // pulse_q tracks the line even while idle so the first RUN cycle sees a true edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= pulse_in;
        end
    end

    assign pulse_edge = pulse_in & ~pulse_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else if (!run || close) begin
            pulse_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else if (pulse_edge) begin
            if (pulse_cnt == {COUNT_W{1'b1}}) begin
                cnt_sat <= 1'b1;
            end else begin
                pulse_cnt <= pulse_cnt + COUNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bpm_window_monitor.sv
// Windowed BPM monitor: counts pulse edges per window, scales to BPM, classifies and alarms.
module bpm_window_monitor
    import bpm_pkg::*;
#(
    parameter int COUNT_W       = DEF_COUNT_W,
    parameter int BPM_W         = DEF_BPM_W,
    parameter int BPM_MULT      = DEF_BPM_MULT,
    parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int ALARM_N       = DEF_ALARM_N
) (
    input  logic                 clk,
    input  logic                 reset,
    bpm_window_monitor_if.slave  bus
);

    localparam int WIN_W    = $clog2(WINDOW_CYCLES);
    localparam int MULT_W   = ($clog2(BPM_MULT + 1) > 0) ? $clog2(BPM_MULT + 1) : 1;
    localparam int PROD_W   = COUNT_W + MULT_W;
    localparam int WIDE_W   = (PROD_W > BPM_W) ? PROD_W : BPM_W;
    localparam int STREAK_W = $clog2(ALARM_N + 1);

    localparam logic [WIN_W-1:0]    WIN_LAST   = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [PROD_W-1:0]   MULT_V     = PROD_W'(BPM_MULT);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(ALARM_N);

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c,
                                                   input logic               inc);
        if (inc && (c != {COUNT_W{1'b1}})) return c + COUNT_W'(1);
        return c;
    endfunction

    function automatic logic [BPM_W-1:0] sat_bpm(input logic [PROD_W-1:0] p);
        logic [WIDE_W-1:0] w;
        w = WIDE_W'(p);
        if (w > WIDE_W'({BPM_W{1'b1}})) return {BPM_W{1'b1}};
        return w[BPM_W-1:0];
    endfunction

    function automatic logic [STREAK_W-1:0] streak_next(input logic [STREAK_W-1:0] s,
                                                        input logic                oor);
        if (!oor) return '0;
        if (s == STREAK_MAX) return s;
        return s + STREAK_W'(1);
    endfunction

    state_t               state_q;
    state_t               state_d;
    logic                 active;
    logic [WIN_W-1:0]     win_cnt;

    logic                 pulse_edge;
    logic [COUNT_W-1:0]   pulse_cnt;
    logic                 cnt_sat;

    logic                 close_p0;
    logic [COUNT_W-1:0]   final_p0;
    logic                 sat_p0;
    logic [PROD_W-1:0]    prod_p0;
    logic [BPM_W-1:0]     bpm_p0;
    logic                 oor_p0;
    logic [STREAK_W-1:0]  streak_p0;

    logic                 vld_p1;
    logic [BPM_W-1:0]     bpm_p1;
    logic                 oor_p1;
    logic                 sat_p1;
    logic                 alarm_p1;
    logic [STREAK_W-1:0]  streak_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.en)  state_d = RUN;
            RUN:     if (!bus.en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // en is qualified here so a window whose close cycle sees en low is dropped
    assign active   = (state_q == RUN) && bus.en;
    assign close_p0 = active && (win_cnt == WIN_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt <= '0;
        end else if (!active || close_p0) begin
            win_cnt <= '0;
        end else begin
            win_cnt <= win_cnt + WIN_W'(1);
        end
    end

    bpm_edge_counter #(
        .COUNT_W (COUNT_W)
    ) u_edge_counter (
        .clk        (clk),
        .reset      (reset),
        .pulse_in   (bus.pulse_in),
        .run        (active),
        .close      (close_p0),
        .pulse_edge (pulse_edge),
        .pulse_cnt  (pulse_cnt),
        .cnt_sat    (cnt_sat)
    );

    // Stage p0: close-cycle result; an edge on the close cycle belongs to this window
    assign final_p0  = sat_inc(pulse_cnt, pulse_edge);
    assign sat_p0    = cnt_sat | (pulse_edge & (pulse_cnt == {COUNT_W{1'b1}}));
    assign prod_p0   = PROD_W'(final_p0) * MULT_V;
    assign bpm_p0    = sat_bpm(prod_p0);
    assign oor_p0    = (bpm_p0 < bus.low_thresh) | (bpm_p0 > bus.high_thresh);
    assign streak_p0 = streak_next(streak_q, oor_p0);

    // Stage p1: registered window result, held until the next close
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            bpm_p1   <= '0;
            oor_p1   <= 1'b0;
            sat_p1   <= 1'b0;
            alarm_p1 <= 1'b0;
            streak_q <= '0;
        end else begin
            vld_p1 <= close_p0;
            if (close_p0) begin
                bpm_p1   <= bpm_p0;
                oor_p1   <= oor_p0;
                sat_p1   <= sat_p0;
                streak_q <= streak_p0;
                alarm_p1 <= (streak_p0 == STREAK_MAX);
            end
        end
    end

    assign bus.bpm       = bpm_p1;
    assign bus.bpm_valid = vld_p1;
    assign bus.bpm_state = oor_p1;
    assign bus.count_sat = sat_p1;
    assign bus.alarm     = alarm_p1;

endmodule

// File: tb/tb_bpm_window_monitor.sv
// Directed bench for bpm_window_monitor: two instances (COUNT_W 8 and 4) share one stimulus.
module tb_bpm_window_monitor;

    localparam int WIN = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        pulse_in;
    logic [11:0] low_thresh;
    logic [11:0] high_thresh;

    int n_tests = 0;
    int n_fail  = 0;

    bpm_window_monitor_if #(.BPM_W(12)) ifa ();
    bpm_window_monitor_if #(.BPM_W(12)) ifb ();

    assign ifa.en          = en;
    assign ifa.pulse_in    = pulse_in;
    assign ifa.low_thresh  = low_thresh;
    assign ifa.high_thresh = high_thresh;
    assign ifb.en          = en;
    assign ifb.pulse_in    = pulse_in;
    assign ifb.low_thresh  = low_thresh;
    assign ifb.high_thresh = high_thresh;

    bpm_window_monitor #(
        .COUNT_W(8), .BPM_W(12), .BPM_MULT(6), .WINDOW_CYCLES(WIN), .ALARM_N(3)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    bpm_window_monitor #(
        .COUNT_W(4), .BPM_W(12), .BPM_MULT(6), .WINDOW_CYCLES(WIN), .ALARM_N(3)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one full window starting in its first RUN cycle: n pulses one-high/one-low
    // from index off, plus an optional pulse on the close cycle.
    task automatic run_window(input int n, input int off, input bit close_edge);
        int strays = 0;
        for (int i = 0; i < WIN; i++) begin
            pulse_in = ((i >= off) && (i < off + 2 * n) && (((i - off) % 2) == 0))
                       || (close_edge && (i == WIN - 1));
            tick();
            if ((i < WIN - 1) && ifa.bpm_valid) strays++;
        end
        pulse_in = 1'b0;
        check("vld_gap", strays, 0);
        check("vld_close", 32'(ifa.bpm_valid), 1);
    endtask

    initial begin
        int vcnt;
        reset       = 1'b1;
        en          = 1'b0;
        pulse_in    = 1'b0;
        low_thresh  = 12'd60;
        high_thresh = 12'd102;
        tick(); tick(); tick();

        check("rst_bpm",   32'(ifa.bpm), 0);
        check("rst_vld",   32'(ifa.bpm_valid), 0);
        check("rst_state", 32'(ifa.bpm_state), 0);
        check("rst_sat",   32'(ifa.count_sat), 0);
        check("rst_alarm", 32'(ifa.alarm), 0);

        reset = 1'b0;
        tick();
        en = 1'b1;
        tick();

        run_window(12, 0, 1'b0);
        check("w12_bpm",   32'(ifa.bpm), 72);
        check("w12_state", 32'(ifa.bpm_state), 0);
        check("w12_sat",   32'(ifa.count_sat), 0);
        check("w12_b_bpm", 32'(ifb.bpm), 72);
        tick();
        check("vld_one_cycle", 32'(ifa.bpm_valid), 0);
        // that tick consumed cycle 0 of the next window; re-enter cleanly via idle
        en = 1'b0;
        tick(); tick();
        en = 1'b1;
        tick();

        run_window(5, 0, 1'b0);
        check("w5_bpm",   32'(ifa.bpm), 30);
        check("w5_state", 32'(ifa.bpm_state), 1);
        check("w5_alarm", 32'(ifa.alarm), 0);

        run_window(18, 0, 1'b0);
        check("w18_bpm",   32'(ifa.bpm), 108);
        check("w18_state", 32'(ifa.bpm_state), 1);
        check("w18_alarm", 32'(ifa.alarm), 0);

        run_window(17, 0, 1'b0);
        check("w17_bpm",   32'(ifa.bpm), 102);
        check("w17_state", 32'(ifa.bpm_state), 0);

        run_window(5, 0, 1'b0);
        check("streak1_alarm", 32'(ifa.alarm), 0);
        run_window(5, 0, 1'b0);
        check("streak2_alarm", 32'(ifa.alarm), 0);
        run_window(5, 0, 1'b0);
        check("streak3_alarm", 32'(ifa.alarm), 1);
        check("streak3_state", 32'(ifa.bpm_state), 1);
        run_window(12, 0, 1'b0);
        check("clear_alarm", 32'(ifa.alarm), 0);
        check("clear_bpm",   32'(ifa.bpm), 72);

        run_window(20, 0, 1'b0);
        check("w20_a_bpm",   32'(ifa.bpm), 120);
        check("w20_a_sat",   32'(ifa.count_sat), 0);
        check("w20_a_state", 32'(ifa.bpm_state), 1);
        check("w20_b_bpm",   32'(ifb.bpm), 90);
        check("w20_b_sat",   32'(ifb.count_sat), 1);
        check("w20_b_state", 32'(ifb.bpm_state), 0);

        run_window(5, 0, 1'b1);
        check("close_edge_bpm", 32'(ifa.bpm), 36);
        run_window(12, 2, 1'b0);
        check("after_close_bpm", 32'(ifa.bpm), 72);
        check("after_close_state", 32'(ifa.bpm_state), 0);

        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            pulse_in = ((i % 2) == 0);
            tick();
            if (ifa.bpm_valid) vcnt++;
        end
        en       = 1'b0;
        pulse_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ifa.bpm_valid) vcnt++;
        end
        check("en_drop_vld",   vcnt, 0);
        check("en_drop_bpm",   32'(ifa.bpm), 72);
        check("en_drop_state", 32'(ifa.bpm_state), 0);
        en = 1'b1;
        tick();
        run_window(17, 0, 1'b0);
        check("en_reentry_bpm", 32'(ifa.bpm), 102);

        run_window(5, 0, 1'b0);
        check("pre_rst_state", 32'(ifa.bpm_state), 1);
        for (int i = 0; i < 20; i++) begin
            pulse_in = ((i % 2) == 0);
            tick();
        end
        pulse_in = 1'b0;
        reset    = 1'b1;
        #1;
        check("async_rst_bpm",   32'(ifa.bpm), 0);
        check("async_rst_state", 32'(ifa.bpm_state), 0);
        check("async_rst_vld",   32'(ifa.bpm_valid), 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        run_window(17, 0, 1'b0);
        check("rst_reentry_bpm",   32'(ifa.bpm), 102);
        check("rst_reentry_alarm", 32'(ifa.alarm), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
